// File: rtl/serial_rx_oversampled_pkg.sv
// Shared definitions for the oversampled serial receiver: FSM state
// encoding, parity mode constants and the parity check helper.
package serial_rx_oversampled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Data is zero-extended to 9 bits so every legal DATA_BITS fits.
  // Returns 1 when the received parity bit disagrees with the mode.
  function automatic logic parity_error(input logic [8:0] data,
                                        input logic       par_bit,
                                        input int         mode);
    logic sum;
    sum = ^{data, par_bit};
    case (mode)
      PARITY_EVEN: return sum;
      PARITY_ODD:  return ~sum;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Show-ahead receive FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB comparison.
module serial_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             popped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             pop;
  logic             wr_en;

  // Status decode; a push into a full FIFO is accepted only when a pop frees a slot.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop    = !empty && pop_req;
    wr_en  = push && (!full || pop);
    valid  = !empty;
    popped = pop;
    if (empty) begin
      head = '0;
    end else begin
      head = mem[rd_ptr[AW-1:0]];
    end
  end

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/serial_rx_oversampled.sv
// Oversampled asynchronous serial receiver: synchronizes the line, finds
// the start bit, samples each bit mid-period and queues words with their
// parity and framing error flags in a show-ahead FIFO.
module serial_rx_oversampled
  import serial_rx_oversampled_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_BAUD_TICK,
  input  logic                 IN_SERIAL_RX,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic                 OUT_PARITY_ERR,
  output logic                 OUT_FRAME_ERR,
  output logic                 OUT_VALID,
  input  logic                 IN_READY,
  output logic                 OUT_OVERRUN,
  input  logic                 IN_CLEAR_OVERRUN,
  output logic                 OUT_STATUS_READY
);

  localparam int WIDTH = DATA_BITS + 2;
  localparam int CW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  rx_state_t            state;
  logic                 sync1;
  logic                 rx;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 frame_err;
  logic                 armed;
  logic                 sample;
  logic                 stop_bad;
  logic                 push;
  logic [WIDTH-1:0]     push_word;
  logic [WIDTH-1:0]     head;
  logic                 fifo_full;
  logic                 fifo_popped;
  logic                 overrun;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= IN_SERIAL_RX;
      rx    <= sync1;
    end
  end

  // Sample strobe and the word assembled on the final stop-bit sample.
  always_comb begin
    sample    = IN_BAUD_TICK && (tick_cnt == LAST_TICK);
    stop_bad  = frame_err | ~rx;
    push      = (state == ST_STOP) && sample && (stop_idx == LAST_STOP);
    push_word = {stop_bad, parity_error(9'(shift_reg), par_bit, PARITY_MODE), shift_reg};
  end

  // Receive FSM; 'armed' requires the line to be seen high in IDLE
  // after reset so reception only starts on a fresh falling edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (IN_BAUD_TICK && rx) begin
            armed <= 1'b1;
          end else if (IN_BAUD_TICK && armed) begin
            armed <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (IN_BAUD_TICK) begin
            if (tick_cnt == HALF_TICK) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx) begin
                state <= ST_DATA;
              end else begin
                armed <= 1'b1;
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            tick_cnt  <= '0;
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              stop_idx  <= 1'b0;
              frame_err <= 1'b0;
              state     <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (IN_BAUD_TICK) begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (sample) begin
            tick_cnt <= '0;
            par_bit  <= rx;
            state    <= ST_STOP;
          end else if (IN_BAUD_TICK) begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (sample) begin
            tick_cnt  <= '0;
            frame_err <= stop_bad;
            if (stop_idx == LAST_STOP) begin
              armed <= ~stop_bad;
              state <= stop_bad ? ST_WAIT_HIGH : ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else if (IN_BAUD_TICK) begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          tick_cnt <= '0;
          if (IN_BAUD_TICK && rx) begin
            armed <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          tick_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  serial_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (push_word),
    .pop_req   (IN_READY),
    .head      (head),
    .valid     (OUT_VALID),
    .full      (fifo_full),
    .popped    (fifo_popped)
  );

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !fifo_popped) begin
      overrun <= 1'b1;
    end else if (IN_CLEAR_OVERRUN) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

  assign OUT_DATA         = head[DATA_BITS-1:0];
  assign OUT_PARITY_ERR   = head[DATA_BITS];
  assign OUT_FRAME_ERR    = head[DATA_BITS+1];
  assign OUT_OVERRUN      = overrun;
  assign OUT_STATUS_READY = (state == ST_IDLE);

endmodule

// File: tb/tb_serial_rx_oversampled.sv
// Scoreboard bench for serial_rx_oversampled: frames are generated at the
// bit level, expected words are queued when sent, and a monitor pops and
// compares every word the DUT hands over.
module tb_serial_rx_oversampled;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int FD = 4;

  typedef struct packed {
    logic          ferr;
    logic          perr;
    logic [DB-1:0] data;
  } word_t;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          IN_BAUD_TICK = 1'b0;
  logic          IN_SERIAL_RX = 1'b1;
  logic          IN_READY = 1'b0;
  logic          IN_CLEAR_OVERRUN = 1'b0;
  logic [DB-1:0] OUT_DATA;
  logic          OUT_PARITY_ERR;
  logic          OUT_FRAME_ERR;
  logic          OUT_VALID;
  logic          OUT_OVERRUN;
  logic          OUT_STATUS_READY;

  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 2;
  logic  exp_overrun = 1'b0;
  word_t sb[$];

  serial_rx_oversampled #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .IN_BAUD_TICK     (IN_BAUD_TICK),
    .IN_SERIAL_RX     (IN_SERIAL_RX),
    .OUT_DATA         (OUT_DATA),
    .OUT_PARITY_ERR   (OUT_PARITY_ERR),
    .OUT_FRAME_ERR    (OUT_FRAME_ERR),
    .OUT_VALID        (OUT_VALID),
    .IN_READY         (IN_READY),
    .OUT_OVERRUN      (OUT_OVERRUN),
    .IN_CLEAR_OVERRUN (IN_CLEAR_OVERRUN),
    .OUT_STATUS_READY (OUT_STATUS_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Baud tick every 4th clock and consumer ready, both driven on the falling edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      IN_BAUD_TICK = (ph == 3);
      ph = (ph + 1) % 4;
      case (ready_mode)
        0:       IN_READY = 1'b0;
        1:       IN_READY = 1'($urandom_range(0, 1));
        default: IN_READY = 1'b1;
      endcase
    end
  end

  // Monitor: whenever the next rising edge will pop, compare the head word.
  always @(negedge CLK) begin
    #1;
    if (RESET_N && OUT_VALID && IN_READY) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected no word", {OUT_FRAME_ERR, OUT_PARITY_ERR, OUT_DATA});
      end else begin
        word_t e;
        e = sb.pop_front();
        check("rx_word", 32'({OUT_FRAME_ERR, OUT_PARITY_ERR, OUT_DATA}), 32'(e));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (!IN_BAUD_TICK) @(posedge CLK);
    end
    #1;
  endtask

  // Reference: even parity error when total ones count (data + parity) is odd.
  task automatic expect_word(input logic [DB-1:0] d, input logic par, input logic stp);
    word_t w;
    w.data = d;
    w.perr = ((($countones(d) + int'(par)) % 2) != 0);
    w.ferr = !stp;
    if (sb.size() >= FD) exp_overrun = 1'b1;
    else sb.push_back(w);
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return 1'(($countones(d)) % 2);
  endfunction

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stp);
    IN_SERIAL_RX = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      IN_SERIAL_RX = d[i];
      wait_ticks(OS);
    end
    IN_SERIAL_RX = par;
    wait_ticks(OS);
    expect_word(d, par, stp);
    IN_SERIAL_RX = stp;
    wait_ticks(OS);
    IN_SERIAL_RX = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    ready_mode = 2;
    while (sb.size() != 0 && budget < 4000) begin
      @(negedge CLK);
      budget++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d words outstanding expected 0", tag, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge CLK);
    #2;
    check({tag, "_empty"}, 32'(OUT_VALID), 32'h0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          p;
    logic          s;
    // Reset state
    ready_mode = 2;
    repeat (5) @(negedge CLK);
    #2;
    check("rst_valid", 32'(OUT_VALID), 32'h0);
    check("rst_data", 32'(OUT_DATA), 32'h0);
    check("rst_perr", 32'(OUT_PARITY_ERR), 32'h0);
    check("rst_ferr", 32'(OUT_FRAME_ERR), 32'h0);
    check("rst_overrun", 32'(OUT_OVERRUN), 32'h0);
    check("rst_status", 32'(OUT_STATUS_READY), 32'h1);
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_ticks(OS);

    // Good frame 0xA5, held in the FIFO for inspection
    ready_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_valid", 32'(OUT_VALID), 32'h1);
    check("a5_data", 32'(OUT_DATA), 32'hA5);
    check("a5_flags", 32'({OUT_FRAME_ERR, OUT_PARITY_ERR}), 32'h0);
    check("a5_status", 32'(OUT_STATUS_READY), 32'h1);
    drain("a5");

    // Short start glitch
    IN_SERIAL_RX = 1'b0;
    wait_ticks(3);
    check("glitch_in_start", 32'(OUT_STATUS_READY), 32'h0);
    wait_ticks(2);
    IN_SERIAL_RX = 1'b1;
    wait_ticks(OS);
    check("glitch_status", 32'(OUT_STATUS_READY), 32'h1);
    check("glitch_valid", 32'(OUT_VALID), 32'h0);

    // Bad parity 0x3C
    ready_mode = 0;
    send_frame(8'h3C, 1'b1, 1'b1);
    check("3c_data", 32'(OUT_DATA), 32'h3C);
    check("3c_perr", 32'(OUT_PARITY_ERR), 32'h1);
    check("3c_ferr", 32'(OUT_FRAME_ERR), 32'h0);
    drain("3c");

    // Overrun: five frames with the consumer stalled
    ready_mode = 0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, good_par(d), 1'b1);
      wait_ticks(OS);
    end
    check("ovr_set", 32'(OUT_OVERRUN), 32'(exp_overrun));
    check("ovr_head", 32'(OUT_DATA), 32'h01);
    @(negedge CLK);
    IN_CLEAR_OVERRUN = 1'b1;
    @(negedge CLK);
    IN_CLEAR_OVERRUN = 1'b0;
    exp_overrun = 1'b0;
    #2;
    check("ovr_clear", 32'(OUT_OVERRUN), 32'(exp_overrun));
    drain("ovr");

    // Break: line low for two frame times
    IN_SERIAL_RX = 1'b0;
    expect_word(8'h00, 1'b0, 1'b0);
    wait_ticks(22 * OS);
    check("break_wait_high", 32'(OUT_STATUS_READY), 32'h0);
    check("break_popped", 32'(OUT_VALID), 32'h0);
    IN_SERIAL_RX = 1'b1;
    wait_ticks(2 * OS);
    check("break_recovered", 32'(OUT_STATUS_READY), 32'h1);
    send_frame(8'h55, good_par(8'h55), 1'b1);
    drain("break");

    // Reset during data bit 4
    IN_SERIAL_RX = 1'b0;
    wait_ticks(OS);
    d = 8'h81;
    for (int i = 0; i < 4; i++) begin
      IN_SERIAL_RX = d[i];
      wait_ticks(OS);
    end
    IN_SERIAL_RX = d[4];
    wait_ticks(OS / 2);
    @(negedge CLK);
    RESET_N = 1'b0;
    #2;
    check("midrst_valid", 32'(OUT_VALID), 32'h0);
    check("midrst_status", 32'(OUT_STATUS_READY), 32'h1);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    IN_SERIAL_RX = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h81, good_par(8'h81), 1'b1);
    drain("midrst");

    // Randomized frames, random parity/stop faults and random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s = ($urandom_range(0, 5) != 0);
      send_frame(d, p, s);
      wait_ticks(OS * int'($urandom_range(1, 3)));
    end
    drain("rand");
    check("final_overrun", 32'(OUT_OVERRUN), 32'(exp_overrun));
    check("final_status", 32'(OUT_STATUS_READY), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
